lattice_sweeper: RTL and testbench

- Upstream sequencer for the bd_math action-delta datapath. Holds the 1-D periodic lattice of Q16.16 site values.
- Walks sites 0..N_SITES-1 per sweep. For each site it presents xm/x/xp plus a random proposal inc, waits for the downstream Metropolis decision, then writes x+inc back when the proposal is accepted.
- One site is in flight at a time, because neighbouring sites depend on each other.

---
 rtl/lattice_pkg.sv | 36 +++
 rtl/xorshift32_rng.sv | 25 ++
 rtl/lattice_sweeper.sv | 142 ++++++++++++++
 tb/tb_lattice_sweeper.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lattice_pkg.sv
// Shared types, Q16.16 constants and RNG helpers for the lattice sweeper.
// Latency: n/a (package).
// Backpressure: n/a (package).
package lattice_pkg;

  localparam int DATA_W = 32;
  localparam int FRAC_W = 16;

  localparam logic [31:0] XORSHIFT_SEED_DEFAULT = 32'h1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_WRITE,
    ST_FINISH
  } state_t;

  // One xorshift32 step: s^=s<<13; s^=s>>17; s^=s<<5.
  function automatic logic [31:0] xorshift32_next(input logic [31:0] s);
    logic [31:0] t;
    t = s;
    t = t ^ (t << 13);
    t = t ^ (t >> 17);
    t = t ^ (t << 5);
    return t;
  endfunction

  // Proposal increment: low 16 RNG bits sign-extended, then arithmetic right shift.
  function automatic logic [31:0] proposal_inc(input logic [31:0] r, input logic [3:0] sh);
    logic signed [31:0] ext;
    ext = $signed({{16{r[15]}}, r[15:0]});
    return ext >>> sh;
  endfunction

endpackage

// File: rtl/xorshift32_rng.sv
// xorshift32 generator with seed load; load wins over step, zero seed maps to the default.
// Latency: new state visible the cycle after load/step.
// Backpressure: none; advances only when stepped.
module xorshift32_rng (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        step,
  output logic [31:0] state
);
  import lattice_pkg::*;

  // Generator state: reseed on load, otherwise advance one step when asked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= XORSHIFT_SEED_DEFAULT;
    end else if (load) begin
      state <= (seed == 32'h0) ? XORSHIFT_SEED_DEFAULT : seed;
    end else if (step) begin
      state <= xorshift32_next(state);
    end
  end

endmodule

// File: rtl/lattice_sweeper.sv
// Sweeps a periodic Q16.16 lattice, issuing one Metropolis proposal per site and applying accepted updates.
// Latency: 3 + D cycles per site (D = cycles from op_valid to dec_valid).
// Backpressure: holds operands in WAIT until dec_valid; start/init_we ignored while busy.
module lattice_sweeper #(
  parameter int N_SITES = 64,
  parameter int ADDR_W  = 6,
  parameter int DATA_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [15:0]       n_sweeps,
  input  logic [3:0]        step_shift,
  input  logic [31:0]       seed,
  input  logic              init_we,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic [DATA_W-1:0] init_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] xm,
  output logic [DATA_W-1:0] x,
  output logic [DATA_W-1:0] xp,
  output logic [DATA_W-1:0] inc,
  output logic              op_valid,
  input  logic              dec_valid,
  input  logic              dec_accept,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] site_idx,
  output logic [15:0]       sweep_count,
  output logic [31:0]       accept_count
);
  import lattice_pkg::*;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] lat [N_SITES];
  logic [15:0]       n_sweeps_q;
  logic [3:0]        shift_q;
  logic              acc_q;
  logic [31:0]       rng_state;
  logic [ADDR_W-1:0] idx_m, idx_p;
  logic              last_site;
  logic              start_ok;

  assign start_ok  = (state == ST_IDLE) && start;
  assign last_site = (site_idx == ADDR_W'(N_SITES - 1));
  assign idx_m     = (site_idx == '0) ? ADDR_W'(N_SITES - 1) : site_idx - ADDR_W'(1);
  assign idx_p     = last_site ? '0 : site_idx + ADDR_W'(1);
  assign busy      = (state != ST_IDLE);
  assign rd_data   = lat[rd_addr];

  xorshift32_rng u_rng (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (start_ok),
    .seed  (seed),
    .step  (state == ST_ISSUE),
    .state (rng_state)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic for the per-site issue/wait/write loop.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start) state_nxt = (n_sweeps == 16'd0) ? ST_FINISH : ST_ISSUE;
      ST_ISSUE:  state_nxt = ST_WAIT;
      ST_WAIT:   if (dec_valid) state_nxt = ST_WRITE;
      ST_WRITE:  state_nxt = (last_site && (sweep_count + 16'd1 == n_sweeps_q)) ? ST_FINISH : ST_ISSUE;
      ST_FINISH: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Run control, operand registers, counters and strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_sweeps_q   <= '0;
      shift_q      <= '0;
      acc_q        <= 1'b0;
      xm           <= '0;
      x            <= '0;
      xp           <= '0;
      inc          <= '0;
      op_valid     <= 1'b0;
      done         <= 1'b0;
      site_idx     <= '0;
      sweep_count  <= '0;
      accept_count <= '0;
    end else begin
      op_valid <= (state == ST_ISSUE);
      done     <= (state == ST_FINISH);
      case (state)
        ST_IDLE: begin
          if (start) begin
            n_sweeps_q   <= n_sweeps;
            shift_q      <= step_shift;
            site_idx     <= '0;
            sweep_count  <= '0;
            accept_count <= '0;
          end
        end
        ST_ISSUE: begin
          xm  <= lat[idx_m];
          x   <= lat[site_idx];
          xp  <= lat[idx_p];
          inc <= DATA_W'(proposal_inc(xorshift32_next(rng_state), shift_q));
        end
        ST_WAIT: begin
          if (dec_valid) acc_q <= dec_accept;
        end
        ST_WRITE: begin
          if (acc_q) accept_count <= accept_count + 32'd1;
          if (last_site) begin
            site_idx    <= '0;
            sweep_count <= sweep_count + 16'd1;
          end else begin
            site_idx <= site_idx + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Lattice storage: host writes while idle, accepted proposals written back in WRITE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_SITES; k++) lat[k] <= '0;
    end else if ((state == ST_IDLE) && init_we && (32'(init_addr) < N_SITES)) begin
      lat[init_addr] <= init_data;
    end else if ((state == ST_WRITE) && acc_q) begin
      lat[site_idx] <= x + inc;
    end
  end

endmodule

// File: tb/tb_lattice_sweeper.sv
// Self-checking bench for lattice_sweeper: table of runs plus a mid-run reset sequence.
// Latency: n/a (testbench).
// Backpressure: decision strobe driven D cycles after each op_valid.
module tb_lattice_sweeper;
  localparam int N  = 64;
  localparam int AW = 6;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [15:0]   n_sweeps = '0;
  logic [3:0]    step_shift = '0;
  logic [31:0]   seed = '0;
  logic          init_we = 1'b0;
  logic [AW-1:0] init_addr = '0;
  logic [DW-1:0] init_data = '0;
  logic [AW-1:0] rd_addr = '0;
  logic [DW-1:0] rd_data, xm, x, xp, inc;
  logic          op_valid, busy, done;
  logic          dec_valid = 1'b0;
  logic          dec_accept = 1'b0;
  logic [AW-1:0] site_idx;
  logic [15:0]   sweep_count;
  logic [31:0]   accept_count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  lattice_sweeper #(.N_SITES(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .n_sweeps(n_sweeps),
    .step_shift(step_shift), .seed(seed), .init_we(init_we),
    .init_addr(init_addr), .init_data(init_data), .rd_addr(rd_addr),
    .rd_data(rd_data), .xm(xm), .x(x), .xp(xp), .inc(inc),
    .op_valid(op_valid), .dec_valid(dec_valid), .dec_accept(dec_accept),
    .busy(busy), .done(done), .site_idx(site_idx),
    .sweep_count(sweep_count), .accept_count(accept_count)
  );

  typedef struct {
    int          pat;
    logic [15:0] nsw;
    logic [3:0]  sh;
    logic [31:0] seed;
    bit          acc;
    int          d;
    bit          chk_first;
    logic [31:0] f_xm, f_x, f_xp, f_inc;
    int          exp_acc;
    int          exp_sw;
    int          exp_cyc;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] m_xs(input logic [31:0] s);
    logic [31:0] t;
    t = s ^ (s << 13);
    t = t ^ (t >> 17);
    t = t ^ (t << 5);
    return t;
  endfunction

  function automatic logic [31:0] m_inc(input logic [31:0] r, input logic [3:0] sh);
    logic signed [31:0] e;
    e = $signed({{16{r[15]}}, r[15:0]});
    return e >>> sh;
  endfunction

  function automatic logic [31:0] pat_val(input int p, input int i);
    case (p)
      1:       return 32'(i) << 16;
      2:       return 32'h7FFF_F000 + 32'(i);
      default: return 32'h0;
    endcase
  endfunction

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_opv"}, 32'(op_valid), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_xm"}, xm, 0);
    chk({tag, "_x"}, x, 0);
    chk({tag, "_xp"}, xp, 0);
    chk({tag, "_inc"}, inc, 0);
    chk({tag, "_site"}, 32'(site_idx), 0);
    chk({tag, "_sweeps"}, 32'(sweep_count), 0);
    chk({tag, "_accepts"}, accept_count, 0);
  endtask

  task automatic run_row(input vec_t v, input int row);
    logic [31:0] lat [N];
    logic [31:0] mr, cur_inc;
    int site, cyc, done_cyc, n_done, n_ops, wait_cnt;
    bit pend, sign_seen;
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      init_we = 1'b1; init_addr = AW'(i); init_data = pat_val(v.pat, i);
      lat[i] = pat_val(v.pat, i);
    end
    @(negedge clk);
    init_we = 1'b0;
    mr = (v.seed == 32'h0) ? 32'h1 : v.seed;
    n_sweeps = v.nsw; step_shift = v.sh; seed = v.seed; start = 1'b1;
    site = 0; cyc = 0; done_cyc = -1; n_done = 0; n_ops = 0;
    wait_cnt = 0; pend = 1'b0; sign_seen = 1'b0; cur_inc = '0;
    while (cyc < 3000 && (done_cyc < 0 || cyc < done_cyc + 3)) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      start = 1'b0; init_we = 1'b0; dec_valid = 1'b0;
      if (done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (op_valid) begin
        mr = m_xs(mr);
        cur_inc = m_inc(mr, v.sh);
        chk("op_xm", xm, lat[(site + N - 1) % N]);
        chk("op_x", x, lat[site]);
        chk("op_xp", xp, lat[(site + 1) % N]);
        chk("op_inc", inc, cur_inc);
        chk("op_site", 32'(site_idx), 32'(site));
        if (n_ops == 0 && v.chk_first) begin
          chk("first_xm", xm, v.f_xm);
          chk("first_x", x, v.f_x);
          chk("first_xp", xp, v.f_xp);
          chk("first_inc", inc, v.f_inc);
        end
        if (v.sh == 4'd4 && mr[15] && !sign_seen) begin
          sign_seen = 1'b1;
          chk("inc_sign_ext", {16'h0, inc[31:16]}, 32'h0000_FFFF);
        end
        if (v.pat == 1 && !v.acc && site == N - 1 && n_ops < N)
          chk("wrap_xp_site63", xp, 32'h0);
        if (n_ops == 3) begin
          start = 1'b1; init_we = 1'b1; init_addr = AW'(5); init_data = 32'hDEAD_BEEF;
        end
        n_ops++;
        pend = 1'b1;
        wait_cnt = v.d;
      end else if (pend) begin
        wait_cnt--;
      end
      if (pend && wait_cnt == 0) begin
        dec_valid = 1'b1; dec_accept = v.acc;
        if (v.acc) lat[site] = lat[site] + cur_inc;
        site = (site + 1) % N;
        pend = 1'b0;
      end
    end
    chk($sformatf("r%0d_done_cycle", row), 32'(done_cyc), 32'(v.exp_cyc));
    chk($sformatf("r%0d_done_pulses", row), 32'(n_done), 1);
    chk($sformatf("r%0d_ops", row), 32'(n_ops), 32'(int'(v.nsw) * N));
    chk($sformatf("r%0d_sweeps", row), 32'(sweep_count), 32'(v.exp_sw));
    chk($sformatf("r%0d_accepts", row), accept_count, 32'(v.exp_acc));
    chk($sformatf("r%0d_busy_after", row), 32'(busy), 0);
    for (int i = 0; i < N; i++) begin
      rd_addr = AW'(i);
      #1;
      chk($sformatf("r%0d_lattice[%0d]", row, i), rd_data, lat[i]);
    end
  endtask

  task automatic reset_mid_wait();
    int cyc, n_ops;
    bit hit;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      init_we = 1'b1; init_addr = AW'(i); init_data = 32'h1111_0000 + 32'(i + 1);
    end
    @(negedge clk);
    init_we = 1'b0;
    n_sweeps = 16'd1; step_shift = 4'd0; seed = 32'h1; start = 1'b1;
    cyc = 0; n_ops = 0; hit = 1'b0;
    while (cyc < 100 && !hit) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      start = 1'b0; dec_valid = 1'b0;
      if (op_valid) begin
        n_ops++;
        if (n_ops < 3) begin
          dec_valid = 1'b1; dec_accept = 1'b1;
        end else begin
          hit = 1'b1;
        end
      end
    end
    chk("rst_reached_third_op", 32'(hit), 1);
    @(posedge clk);
    #2;
    chk("rst_pre_busy", 32'(busy), 1);
    chk("rst_pre_accepts", accept_count, 2);
    rst_n = 1'b0;
    rd_addr = AW'(1);
    #1;
    check_idle_outputs("rst_mid");
    chk("rst_mid_lat1", rd_data, 32'h0);
    rd_addr = AW'(3);
    #1;
    chk("rst_mid_lat3", rd_data, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    //            pat nsw    sh  seed          acc d  chk  f_xm          f_x    f_xp          f_inc         acc sw cyc
    tbl[0] = '{0, 16'd1, 4'd0, 32'h1,         1'b1, 0, 1'b1, 32'h0,        32'h0, 32'h0,        32'h0000_2021, 64,  1, 194};
    tbl[1] = '{0, 16'd1, 4'd4, 32'h1,         1'b0, 0, 1'b1, 32'h0,        32'h0, 32'h0,        32'h0000_0202, 0,   1, 194};
    tbl[2] = '{1, 16'd1, 4'd0, 32'h1,         1'b1, 0, 1'b1, 32'h003F_0000, 32'h0, 32'h0001_0000, 32'h0000_2021, 64,  1, 194};
    tbl[3] = '{1, 16'd3, 4'd8, 32'h0,         1'b0, 0, 1'b1, 32'h003F_0000, 32'h0, 32'h0001_0000, 32'h0000_0020, 0,   3, 578};
    tbl[4] = '{1, 16'd0, 4'd0, 32'h1,         1'b1, 0, 1'b0, 32'h0,        32'h0, 32'h0,        32'h0,         0,   0, 2};
    tbl[5] = '{2, 16'd1, 4'd0, 32'hDEAD_BEEF, 1'b1, 2, 1'b0, 32'h0,        32'h0, 32'h0,        32'h0,         64,  1, 322};
    tbl[6] = '{1, 16'd2, 4'd4, 32'h1234_5678, 1'b1, 1, 1'b0, 32'h0,        32'h0, 32'h0,        32'h0,         128, 2, 514};

    #1;
    check_idle_outputs("reset");
    rd_addr = AW'(7);
    #1;
    chk("reset_lat7", rd_data, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int r = 0; r < 7; r++) run_row(tbl[r], r);

    reset_mid_wait();
    run_row(tbl[0], 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
